// File: rtl/fetch_unit_if.sv
// Purpose: bundles the fetch unit's execute-side and instruction-memory-side signals.
// Latency: none (wires only).
// Backpressure: execute applies stall; memory answers requests with imem_ready.
interface fetch_unit_if;
    logic [31:0] pc_in;
    logic        stall;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        ir_valid;
    logic        addr_err;
    logic        fetch_err;
    logic [31:0] instr_cnt;

    // Fetch unit side
    modport master (
        input  pc_in, stall, imem_rdata, imem_ready,
        output imem_req, imem_addr, pc, ir, ir_valid, addr_err, fetch_err, instr_cnt
    );

    // Execute stage / instruction memory side
    modport slave (
        output pc_in, stall, imem_rdata, imem_ready,
        input  imem_req, imem_addr, pc, ir, ir_valid, addr_err, fetch_err, instr_cnt
    );
endinterface

// File: rtl/fetch_unit.sv
// Purpose: single-outstanding instruction fetch with alignment trap and fetch timeout.
// Latency: ir/ir_valid one cycle after imem_ready; first request two cycles after reset release.
// Backpressure: stall holds the valid instruction indefinitely; a memory that never answers halts the unit.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0080,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] cnt_q;
    logic [7:0]  wait_q;
    logic        aerr_q;
    logic        ferr_q;

    logic        fetch_done;
    logic        timeout;
    logic        retire;
    logic        misaligned;

    // Alignment check on the offered next-PC; only meaningful at retire.
    assign misaligned = (bus.pc_in[1:0] != 2'b00);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; inputs are only looked at in the states that own them.
    always_comb begin
        state_nxt  = state;
        fetch_done = 1'b0;
        timeout    = 1'b0;
        retire     = 1'b0;
        case (state)
            S_BOOT: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ready) begin
                    // A response on the final allowed cycle still wins over the timeout.
                    fetch_done = 1'b1;
                    state_nxt  = S_VALID;
                end else if (wait_q + 8'd1 == TIMEOUT) begin
                    timeout   = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            S_VALID: begin
                if (!bus.stall) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_BOOT;
            end
        endcase
    end

    // Datapath: pc/ir capture, retire counter, wait counter and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            ir_q   <= 32'd0;
            cnt_q  <= 32'd0;
            wait_q <= 8'd0;
            aerr_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (fetch_done) begin
                ir_q <= bus.imem_rdata;
            end
            if (retire) begin
                cnt_q <= cnt_q + 32'd1;
                pc_q  <= misaligned ? TRAP_PC : bus.pc_in;
            end
            // Counts idle request cycles; zero whenever a fresh fetch begins.
            if (state == S_FETCH && !bus.imem_ready && !timeout) begin
                wait_q <= wait_q + 8'd1;
            end else begin
                wait_q <= 8'd0;
            end
            aerr_q <= retire && misaligned;
            if (timeout) begin
                ferr_q <= 1'b1;
            end
        end
    end

    // Outputs are registers or decodes of the state register only.
    assign bus.imem_req  = (state == S_FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = (state == S_VALID);
    assign bus.addr_err  = aerr_q;
    assign bus.fetch_err = ferr_q;
    assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: self-checking bench for fetch_unit with a memory responder and expected-fetch queue.
// Latency: checks the 1-cycle fetch latency and the 2-cycle boot-to-request delay.
// Backpressure: exercises stall holds, delayed imem_ready and the fetch timeout.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC  = 32'h0000_0080;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;

    logic clk;
    logic rst_n;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks;
    int          errors;
    exp_t        sb[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_aerr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h2001_0005;
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    // Asserts reset between edges, checks reset values before the next edge,
    // releases and leaves the bench at the first S_FETCH negedge.
    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.stall      = 1'b0;
        bus.pc_in      = 32'hDEAD_BEEF;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (bus.pc !== RESET_PC || bus.ir !== 32'd0 || bus.instr_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: pc=%h ir=%h cnt=%0d expected pc=%h ir=0 cnt=0",
                     bus.pc, bus.ir, bus.instr_cnt, RESET_PC);
        end
        checks++;
        if (bus.ir_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.addr_err !== 1'b0 ||
            bus.fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b req=%b aerr=%b ferr=%b expected all 0",
                     bus.ir_valid, bus.imem_req, bus.addr_err, bus.fetch_err);
        end
        sb.delete();
        exp_pc   = RESET_PC;
        exp_cnt  = 32'd0;
        exp_aerr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b0 || bus.ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_cycle: req=%b valid=%b expected 0 0", bus.imem_req, bus.ir_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.ir !== 32'd0) begin
            errors++;
            $display("FAIL boot_ir_ignored: ir=%h expected 00000000", bus.ir);
        end
        bus.imem_ready = 1'b0;
    endtask

    // One instruction: fetch with 'delay' idle cycles, hold 'stalls' cycles, retire with pc_in=nxt.
    // Entered and left at a negedge with the DUT in S_FETCH.
    task automatic run_instr(input int delay, input int stalls, input logic [31:0] nxt);
        exp_t        e;
        logic [31:0] w;
        e.pc = 32'hX;
        e.ir = 32'hX;
        for (int i = 0; i <= delay; i++) begin
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
                errors++;
                $display("FAIL fetch_req: req=%b addr=%h expected req=1 addr=%h",
                         bus.imem_req, bus.imem_addr, exp_pc);
            end
            checks++;
            if (bus.addr_err !== ((i == 0) ? exp_aerr : 1'b0)) begin
                errors++;
                $display("FAIL addr_err: got %b expected %b (fetch cycle %0d)",
                         bus.addr_err, (i == 0) ? exp_aerr : 1'b0, i);
            end
            checks++;
            if (bus.ir_valid !== 1'b0 || bus.fetch_err !== 1'b0) begin
                errors++;
                $display("FAIL fetch_flags: valid=%b ferr=%b expected 0 0", bus.ir_valid, bus.fetch_err);
            end
            bus.stall = 1'($urandom);
            bus.pc_in = $urandom;
            if (i == delay) begin
                w = mem_word(exp_pc);
                bus.imem_ready = 1'b1;
                bus.imem_rdata = w;
                sb.push_back('{pc: exp_pc, ir: w});
            end else begin
                bus.imem_ready = 1'b0;
                bus.imem_rdata = $urandom;
            end
            @(negedge clk);
        end
        exp_aerr = 1'b0;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: no expected fetch queued");
        end else begin
            e = sb.pop_front();
        end
        checks++;
        if (bus.ir_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL valid_state: valid=%b req=%b expected 1 0", bus.ir_valid, bus.imem_req);
        end
        checks++;
        if (bus.pc !== e.pc || bus.ir !== e.ir) begin
            errors++;
            $display("FAIL fetched: pc=%h ir=%h expected pc=%h ir=%h", bus.pc, bus.ir, e.pc, e.ir);
        end
        for (int s = 0; s < stalls; s++) begin
            bus.stall      = 1'b1;
            bus.pc_in      = $urandom;
            bus.imem_ready = 1'b1;
            bus.imem_rdata = $urandom;
            @(negedge clk);
            checks++;
            if (bus.ir_valid !== 1'b1 || bus.pc !== e.pc || bus.ir !== e.ir ||
                bus.instr_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL stall_hold: valid=%b pc=%h ir=%h cnt=%0d expected 1 %h %h %0d",
                         bus.ir_valid, bus.pc, bus.ir, bus.instr_cnt, e.pc, e.ir, exp_cnt);
            end
        end
        bus.stall      = 1'b0;
        bus.pc_in      = nxt;
        bus.imem_ready = 1'b0;
        @(negedge clk);
        exp_cnt  = exp_cnt + 32'd1;
        exp_aerr = (nxt[1:0] != 2'b00);
        exp_pc   = exp_aerr ? TRAP_PC : nxt;
        checks++;
        if (bus.instr_cnt !== exp_cnt || bus.ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL retire: cnt=%0d valid=%b expected cnt=%0d valid=0",
                     bus.instr_cnt, bus.ir_valid, exp_cnt);
        end
    endtask

    task automatic test_boot();
        apply_reset();
        run_instr(0, 0, 32'h4);
    endtask

    task automatic test_sequential();
        apply_reset();
        run_instr(0, 0, 32'h4);
        run_instr(0, 0, 32'h8);
        run_instr(0, 0, 32'hC);
        checks++;
        if (bus.instr_cnt !== 32'd3 || bus.imem_addr !== 32'hC) begin
            errors++;
            $display("FAIL sequential: cnt=%0d addr=%h expected 3 0000000c", bus.instr_cnt, bus.imem_addr);
        end
        run_instr(2, 0, 32'h10);
        run_instr(1, 0, 32'h100);
    endtask

    task automatic test_stall();
        run_instr(0, 5, 32'h200);
        run_instr(3, 1, 32'h204);
    endtask

    task automatic test_misaligned();
        run_instr(0, 0, 32'h0000_0042);
        checks++;
        if (bus.addr_err !== 1'b1 || bus.imem_addr !== 32'h0000_0080) begin
            errors++;
            $display("FAIL misaligned: aerr=%b addr=%h expected 1 00000080", bus.addr_err, bus.imem_addr);
        end
        run_instr(1, 0, 32'h0000_0084);
        run_instr(0, 2, 32'h0000_0303);
        run_instr(2, 0, 32'h0000_0401);
        run_instr(0, 0, 32'h0000_0500);
    endtask

    task automatic test_timeout();
        logic [31:0] hold_pc;
        apply_reset();
        run_instr(0, 0, 32'h40);
        hold_pc = exp_pc;
        for (int k = 0; k < 255; k++) begin
            checks++;
            if (bus.imem_req !== 1'b1 || bus.fetch_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait: req=%b ferr=%b expected 1 0 at cycle %0d",
                         bus.imem_req, bus.fetch_err, k);
            end
            bus.imem_ready = 1'b0;
            bus.imem_rdata = $urandom;
            @(negedge clk);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (bus.fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.ir_valid !== 1'b0 ||
                bus.pc !== hold_pc || bus.ir !== mem_word(32'd0) || bus.instr_cnt !== 32'd1) begin
                errors++;
                $display("FAIL halt: ferr=%b req=%b valid=%b pc=%h ir=%h cnt=%0d expected 1 0 0 %h %h 1",
                         bus.fetch_err, bus.imem_req, bus.ir_valid, bus.pc, bus.ir, bus.instr_cnt,
                         hold_pc, mem_word(32'd0));
            end
            bus.imem_ready = 1'b1;
            bus.imem_rdata = $urandom;
            bus.stall      = 1'b0;
            bus.pc_in      = $urandom;
            @(negedge clk);
        end
    endtask

    task automatic test_timeout_edge();
        apply_reset();
        run_instr(254, 0, 32'h8);
        checks++;
        if (bus.fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_edge: ferr=%b expected 0", bus.fetch_err);
        end
        run_instr(0, 0, 32'hC);
    endtask

    task automatic test_async_reset();
        apply_reset();
        run_instr(0, 0, 32'h4);
        run_instr(0, 0, 32'h8);
        checks++;
        if (bus.instr_cnt !== 32'd2 || bus.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: cnt=%0d req=%b expected 2 1", bus.instr_cnt, bus.imem_req);
        end
        bus.imem_ready = 1'b0;
        apply_reset();
        run_instr(0, 0, 32'h4);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.pc_in      = 32'd0;
        bus.stall      = 1'b0;
        bus.imem_rdata = 32'd0;
        bus.imem_ready = 1'b0;
        exp_pc         = RESET_PC;
        exp_cnt        = 32'd0;
        exp_aerr       = 1'b0;
        test_boot();
        test_sequential();
        test_stall();
        test_misaligned();
        test_timeout();
        test_timeout_edge();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- TRAP_PC, 32'h0000_0080, redirect target for a misaligned next-PC.
- TIMEOUT, 8'd255, maximum S_FETCH cycles without imem_ready.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- pc_in, input, 32, next-PC from the jump/branch next-PC logic.
- stall, input, 1, execute stage holds the current instruction.
- imem_rdata, input, 32, instruction memory read data.
- imem_ready, input, 1, imem_rdata is valid this cycle.
- imem_req, output, 1, fetch request.
- imem_addr, output, 32, fetch address.
- pc, output, 32, address of the instruction in ir.
- ir, output, 32, fetched instruction.
- ir_valid, output, 1, ir/pc are valid for execute.
- addr_err, output, 1, one-cycle pulse on a misaligned pc_in.
- fetch_err, output, 1, sticky fetch timeout flag.
- instr_cnt, output, 32, count of retired instructions.

Function
REQ-003 FSM states: S_BOOT, S_FETCH, S_VALID, S_HALT; encoding is free.
REQ-004 S_BOOT lasts exactly one cycle after rst_n deasserts, then moves to S_FETCH with pc=RESET_PC.
REQ-005 S_FETCH behaviour:
- imem_req=1 and imem_addr=pc, driven combinationally from the state register.
- On imem_ready=1: ir<=imem_rdata, go to S_VALID next cycle, so fetch latency is 1 cycle after ready.
REQ-006 In S_FETCH, a 8-bit wait counter increments each cycle imem_ready=0 and clears on entry to S_FETCH.
REQ-007 Timeout: if the wait counter reaches TIMEOUT with imem_ready=0, set fetch_err=1, go to S_HALT, and drop imem_req.
REQ-008 imem_ready=1 on the same cycle the counter reaches TIMEOUT counts as a successful fetch; fetch_err stays 0.
REQ-009 In S_VALID: ir_valid=1, imem_req=0, and pc and ir are held.
REQ-010 S_VALID with stall=1 holds state, pc, ir and instr_cnt unchanged; there is no limit on how long a stall lasts.
REQ-011 S_VALID with stall=0 retires the instruction:
- instr_cnt<=instr_cnt+1, wrapping modulo 2^32.
- Next state S_FETCH.
- If pc_in[1:0]==2'b00: pc<=pc_in.
- Otherwise: pc<=TRAP_PC and addr_err=1 for exactly that next cycle.
REQ-012 pc_in and stall are sampled only in S_VALID; they are ignored in all other states.
REQ-013 imem_ready or imem_rdata outside S_FETCH is ignored, and ir does not change.
REQ-014 S_HALT is absorbing: only rst_n exits it. In S_HALT, ir_valid=0, imem_req=0, and pc holds the address that timed out.
REQ-015 ir_valid=1 only in S_VALID; ir keeps its last value in all other states.
REQ-016 pc+4 arithmetic is not performed here; pc_in is taken as-is apart from the alignment check.

Reset
REQ-017 rst_n=0 immediately forces:
- state=S_BOOT, pc=RESET_PC, ir=0, instr_cnt=0.
- ir_valid=0, imem_req=0, addr_err=0, fetch_err=0, wait counter=0.
REQ-018 Reset asserted mid-fetch or mid-stall aborts the operation with no retire and no counter update; the first request after release is issued at RESET_PC, two cycles after the release edge.
REQ-019 Outputs are fully registered or decoded from registered state; there is no combinational path from input to output except none required.

Verification
REQ-020 Boot: release rst_n, imem_ready=1 with rdata=32'h2001_0005 -> imem_addr=0 in cycle 2, ir=32'h2001_0005 and ir_valid=1 in cycle 3.
REQ-021 Sequential flow: stall=0, pc_in=pc+4, ready every S_FETCH -> pc steps 0,4,8,C; instr_cnt=3 after the third retire.
REQ-022 Stall: stall=1 for 5 cycles in S_VALID, with pc_in changing -> pc, ir and instr_cnt are constant and ir_valid stays 1; the retire happens on the first stall=0 cycle.
REQ-023 Misaligned: pc_in=32'h0000_0042 at retire -> addr_err pulses 1 cycle, then imem_addr=32'h0000_0080.
REQ-024 Timeout: imem_ready held 0 -> fetch_err=1 after 255 request cycles, imem_req=0, and stays there until reset; a second run with ready on cycle 255 fetches normally.
REQ-025 Async reset: assert rst_n=0 mid-S_FETCH (asynchronously, between edges) -> all outputs reach reset values before the next edge; instr_cnt=0.
